// File: rtl/codec_config_seq.sv
// Power-up configuration sequencer for a WM8731-style codec.
// Walks an 11-entry register table and hands each write to the I2C byte master.
module codec_config_seq #(
    parameter logic [6:0]  DEV_ADDR       = 7'h1A,
    parameter logic [31:0] STARTUP_CYCLES = 32'd2500,
    parameter logic [15:0] GAP_CYCLES     = 16'd25,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       wr_req,
    output logic [6:0] wr_dev_addr,
    output logic [7:0] wr_byte_hi,
    output logic [7:0] wr_byte_lo,
    input  logic       wr_ack,
    input  logic       wr_done,
    input  logic       wr_nack,
    output logic [3:0] entry_idx,
    output logic       config_done,
    output logic       config_error
);

    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [3:0] LAST_IDX = 4'd10;

    typedef enum logic [2:0] {
        S_STARTUP,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    // {reg_addr[6:0], data[8:0]} for each table entry
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    return {7'd15, 9'h000};
            4'd1:    return {7'd6,  9'h010};
            4'd2:    return {7'd0,  9'h017};
            4'd3:    return {7'd1,  9'h017};
            4'd4:    return {7'd2,  9'h079};
            4'd5:    return {7'd3,  9'h079};
            4'd6:    return {7'd4,  9'h012};
            4'd7:    return {7'd5,  9'h000};
            4'd8:    return {7'd7,  9'h002};
            4'd9:    return {7'd8,  9'h000};
            4'd10:   return {7'd9,  9'h001};
            default: return 16'h0000;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [31:0]   start_cnt_q, start_cnt_d;
    logic [15:0]   gap_cnt_q, gap_cnt_d;
    logic [31:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [3:0]    idx_q, idx_d;
    logic          wr_req_q, wr_req_d;
    logic [7:0]    byte_hi_q, byte_hi_d;
    logic [7:0]    byte_lo_q, byte_lo_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic [15:0]   tbl;
    logic          issue_go;
    logic          tmo_hit;
    logic          restart;

    assign tbl     = table_word(idx_q);
    assign tmo_hit = (tmo_cnt_q >= TIMEOUT_CYCLES - 32'd1);
    assign restart = start && (state_q == S_DONE || state_q == S_ERROR);

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_d     = retry_q;
        idx_d       = idx_q;
        wr_req_d    = wr_req_q;
        byte_hi_d   = byte_hi_q;
        byte_lo_d   = byte_lo_q;
        done_d      = done_q;
        error_d     = error_q;
        issue_go    = 1'b0;

        case (state_q)
            S_STARTUP: begin
                if (start_cnt_q >= STARTUP_CYCLES - 32'd1) begin
                    issue_go    = 1'b1;
                    start_cnt_d = '0;
                end else if (start_cnt_q != '1) begin
                    start_cnt_d = start_cnt_q + 32'd1;
                end
            end
            S_ISSUE: begin
                if (wr_ack) begin
                    wr_req_d  = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wr_done && !wr_nack) begin
                    retry_d   = '0;
                    idx_d     = idx_q + 4'd1;
                    gap_cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (wr_done || tmo_hit) begin
                    // a NACK and a timeout are both just a failed attempt
                    if (32'(retry_q) < MAX_RETRIES) begin
                        retry_d   = retry_q + RW'(1);
                        gap_cnt_d = '0;
                        state_d   = S_GAP;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q >= GAP_CYCLES - 16'd1) begin
                    issue_go  = 1'b1;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q != '1) begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: ;
        endcase

        // bytes are latched on entry to S_ISSUE and held through the transaction
        if (issue_go) begin
            state_d   = S_ISSUE;
            wr_req_d  = 1'b1;
            byte_hi_d = tbl[15:8];
            byte_lo_d = tbl[7:0];
        end

        if (restart) begin
            state_d     = S_STARTUP;
            start_cnt_d = '0;
            gap_cnt_d   = '0;
            tmo_cnt_d   = '0;
            retry_d     = '0;
            idx_d       = '0;
            done_d      = 1'b0;
            error_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_STARTUP;
            start_cnt_q <= '0;
            gap_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_q     <= '0;
            idx_q       <= '0;
            wr_req_q    <= 1'b0;
            byte_hi_q   <= '0;
            byte_lo_q   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            idx_q       <= idx_d;
            wr_req_q    <= wr_req_d;
            byte_hi_q   <= byte_hi_d;
            byte_lo_q   <= byte_lo_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign wr_req       = wr_req_q;
    assign wr_dev_addr  = DEV_ADDR;
    assign wr_byte_hi   = byte_hi_q;
    assign wr_byte_lo   = byte_lo_q;
    assign entry_idx    = idx_q;
    assign config_done  = done_q;
    assign config_error = error_q;

endmodule
